// File: rtl/pd2_pwr_pkg.sv
// PD2 power-domain shared types and defaults.
// Used by the PD2 power FSM and the power-switch sequencer.
package pd2_pwr_pkg;

   localparam int PD2_NUM_SEG     = 4;
   localparam int PD2_SEG_DLY     = 8;
   localparam int PD2_SETTLE_DLY  = 16;
   localparam int PD2_ACK_TIMEOUT = 64;

   typedef enum logic [2:0] {
      SW_OFF       = 3'd0,
      SW_RAMP_UP   = 3'd1,
      SW_SETTLE    = 3'd2,
      SW_ON        = 3'd3,
      SW_RAMP_DOWN = 3'd4
   } pd2_sw_state_e;

   typedef enum logic [1:0] {
      PD2_FSM_OFF    = 2'd0,
      PD2_FSM_PWR_UP = 2'd1,
      PD2_FSM_ON     = 2'd2,
      PD2_FSM_PWR_DN = 2'd3
   } pd2_fsm_state_e;

   function automatic int pd2_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pwr_dly_cnt.sv
// Shared step/settle/timeout counter for the PD2 switch sequencer.
// Synchronous clear beats enable; o_tc flags equality with i_tc.
module pwr_dly_cnt #(
   parameter int W = 7
) (
   input  logic         i_aon_clk,
   input  logic         i_soc_pwr_on_rst,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_tc,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
      if (i_soc_pwr_on_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == i_tc);

endmodule

// File: rtl/pd2_pwr_sw_seq.sv
// PD2 power-switch sequencer: thermometer ramp of switch segments,
// rail settle/ack handshake, and sticky fabric-ack timeout.
module pd2_pwr_sw_seq
   import pd2_pwr_pkg::*;
#(
   parameter int NUM_SEG     = PD2_NUM_SEG,
   parameter int SEG_DLY     = PD2_SEG_DLY,
   parameter int SETTLE_DLY  = PD2_SETTLE_DLY,
   parameter int ACK_TIMEOUT = PD2_ACK_TIMEOUT
) (
   input  logic               i_aon_clk,
   input  logic               i_soc_pwr_on_rst,
   input  logic               i_pwr_on_req,
   input  logic               i_sw_ack,
   input  logic               i_err_clr,
   output logic [NUM_SEG-1:0] o_sw_en,
   output logic               o_pwr_on_ack,
   output logic               o_timeout_err
);

   localparam int CW =
      $clog2(pd2_max3(SEG_DLY, SETTLE_DLY, ACK_TIMEOUT) + 1);

   localparam logic [CW-1:0] L_SEG_TC    = CW'(SEG_DLY - 1);
   localparam logic [CW-1:0] L_SETTLE_TC = CW'(SETTLE_DLY - 1);
   localparam logic [CW-1:0] L_ACK_TC    = CW'(ACK_TIMEOUT - 1);
   localparam logic [NUM_SEG-1:0] L_SEG0 = NUM_SEG'(1);

   pd2_sw_state_e      r_state;
   pd2_sw_state_e      w_nxt_state;
   logic [NUM_SEG-1:0] r_sw_en;
   logic [NUM_SEG-1:0] w_nxt_sw_en;
   logic               r_ack;
   logic               w_nxt_ack;
   logic               r_err;
   logic               w_to_set;
   logic               w_cnt_clr;
   logic               w_cnt_en;
   logic               w_tc;
   logic [CW-1:0]      w_cnt;
   logic [CW-1:0]      w_tc_val;

   assign w_cnt_en = (r_state == SW_RAMP_UP) ||
                     (r_state == SW_SETTLE)  ||
                     (r_state == SW_RAMP_DOWN);

   assign w_tc_val = (r_state == SW_SETTLE) ? L_ACK_TC : L_SEG_TC;

   pwr_dly_cnt #(
      .W (CW)
   ) u_cnt (
      .i_aon_clk        (i_aon_clk),
      .i_soc_pwr_on_rst (i_soc_pwr_on_rst),
      .i_clr            (w_cnt_clr),
      .i_en             (w_cnt_en),
      .i_tc             (w_tc_val),
      .o_cnt            (w_cnt),
      .o_tc             (w_tc)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_sw_en = r_sw_en;
      w_nxt_ack   = r_ack;
      w_cnt_clr   = 1'b0;
      w_to_set    = 1'b0;
      unique case (r_state)
         SW_OFF: begin
            if (i_pwr_on_req && !r_err) begin
               w_nxt_state = SW_RAMP_UP;
               w_cnt_clr   = 1'b1;
            end
         end
         SW_RAMP_UP: begin
            // First RAMP_UP cycle turns on segment 0 without waiting
            if (!r_sw_en[0]) begin
               if (!i_pwr_on_req) begin
                  w_nxt_state = SW_OFF;
               end else begin
                  w_nxt_sw_en = L_SEG0;
                  w_cnt_clr   = 1'b1;
               end
            end else if (!i_pwr_on_req) begin
               w_nxt_state = SW_RAMP_DOWN;
               w_cnt_clr   = 1'b1;
            end else if (w_tc) begin
               w_cnt_clr = 1'b1;
               if (r_sw_en[NUM_SEG-1]) begin
                  w_nxt_state = SW_SETTLE;
               end else begin
                  w_nxt_sw_en = {r_sw_en[NUM_SEG-2:0], 1'b1};
               end
            end
         end
         SW_SETTLE: begin
            if (!i_pwr_on_req) begin
               w_nxt_state = SW_RAMP_DOWN;
               w_cnt_clr   = 1'b1;
            end else if (i_sw_ack && (w_cnt >= L_SETTLE_TC)) begin
               w_nxt_state = SW_ON;
               w_nxt_ack   = 1'b1;
            end else if (w_tc) begin
               w_nxt_state = SW_RAMP_DOWN;
               w_to_set    = 1'b1;
               w_cnt_clr   = 1'b1;
            end
         end
         SW_ON: begin
            if (!i_pwr_on_req) begin
               w_nxt_state = SW_RAMP_DOWN;
               w_cnt_clr   = 1'b1;
            end
         end
         SW_RAMP_DOWN: begin
            // Leaving ON: drop ack and top segment together, at once
            if (r_ack) begin
               w_nxt_ack   = 1'b0;
               w_nxt_sw_en = r_sw_en >> 1;
               w_cnt_clr   = 1'b1;
            end else if (i_pwr_on_req && !r_err) begin
               w_nxt_state = SW_RAMP_UP;
               w_cnt_clr   = 1'b1;
            end else if (w_tc) begin
               w_nxt_sw_en = r_sw_en >> 1;
               w_cnt_clr   = 1'b1;
               if (r_sw_en == L_SEG0) begin
                  w_nxt_state = SW_OFF;
               end
            end
         end
         default: begin
            w_nxt_state = SW_OFF;
            w_nxt_sw_en = '0;
            w_nxt_ack   = 1'b0;
            w_cnt_clr   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
      if (i_soc_pwr_on_rst) begin
         r_state <= SW_OFF;
         r_sw_en <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_sw_en <= w_nxt_sw_en;
         r_ack   <= w_nxt_ack;
         if (w_to_set) begin
            r_err <= 1'b1;
         end else if (i_err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign o_sw_en       = r_sw_en;
   assign o_pwr_on_ack  = r_ack;
   assign o_timeout_err = r_err;

endmodule

// File: tb/tb_pd2_pwr_sw_seq.sv
// Bench for pd2_pwr_sw_seq: directed power scenarios, then random
// request/ack/clear traffic against a segment-count reference model.
module tb_pd2_pwr_sw_seq;

   localparam int NUM_SEG     = 4;
   localparam int SEG_DLY     = 8;
   localparam int SETTLE_DLY  = 16;
   localparam int ACK_TIMEOUT = 64;

   localparam int M_OFF    = 0;
   localparam int M_UP     = 1;
   localparam int M_SETTLE = 2;
   localparam int M_ON     = 3;
   localparam int M_DOWN   = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req = 1'b0;
   logic         sack = 1'b0;
   logic         clr = 1'b0;
   logic [NUM_SEG-1:0] sw_en;
   logic         ack_o;
   logic         err_o;

   int  n_chk = 0;
   int  n_pass = 0;
   int  n_fail = 0;
   int  e = 0;

   int  m_mode = M_OFF;
   int  m_lvl = 0;
   int  m_since = 0;
   bit  m_err = 1'b0;
   bit  m_ack = 1'b0;

   always #5 clk = ~clk;

   pd2_pwr_sw_seq #(
      .NUM_SEG     (NUM_SEG),
      .SEG_DLY     (SEG_DLY),
      .SETTLE_DLY  (SETTLE_DLY),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .i_aon_clk        (clk),
      .i_soc_pwr_on_rst (rst),
      .i_pwr_on_req     (req),
      .i_sw_ack         (sack),
      .i_err_clr        (clr),
      .o_sw_en          (sw_en),
      .o_pwr_on_ack     (ack_o),
      .o_timeout_err    (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s edge %0d: got %0h, expected %0h",
                tag, e, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_OFF;
      m_lvl   = 0;
      m_since = 0;
      m_err   = 1'b0;
      m_ack   = 1'b0;
   endtask

   // Model tracks the number of conducting segments and edges since
   // the last sequencing event.
   task automatic model_step();
      bit to;
      to = 1'b0;
      case (m_mode)
         M_OFF: begin
            if (req && !m_err) begin
               m_mode  = M_UP;
               m_since = 0;
            end
         end
         M_UP: begin
            m_since++;
            if (m_lvl == 0) begin
               if (!req) m_mode = M_OFF;
               else begin
                  m_lvl   = 1;
                  m_since = 0;
               end
            end else if (!req) begin
               m_mode  = M_DOWN;
               m_since = 0;
            end else if (m_since == SEG_DLY) begin
               m_since = 0;
               if (m_lvl == NUM_SEG) m_mode = M_SETTLE;
               else m_lvl++;
            end
         end
         M_SETTLE: begin
            m_since++;
            if (!req) begin
               m_mode  = M_DOWN;
               m_since = 0;
            end else if (sack && m_since >= SETTLE_DLY) begin
               m_mode = M_ON;
               m_ack  = 1'b1;
            end else if (m_since == ACK_TIMEOUT) begin
               to      = 1'b1;
               m_mode  = M_DOWN;
               m_since = 0;
            end
         end
         M_ON: begin
            if (!req) m_mode = M_DOWN;
         end
         default: begin
            m_since++;
            if (m_ack) begin
               m_ack   = 1'b0;
               m_lvl--;
               m_since = 0;
            end else if (req && !m_err) begin
               m_mode  = M_UP;
               m_since = 0;
            end else if (m_since == SEG_DLY) begin
               m_since = 0;
               m_lvl--;
               if (m_lvl == 0) m_mode = M_OFF;
            end
         end
      endcase
      if (to) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
   endtask

   task automatic cmp_all(input string tag);
      chk({tag, "_sw_en"}, 32'(sw_en), 32'((1 << m_lvl) - 1));
      chk({tag, "_ack"}, 32'(ack_o), 32'(m_ack));
      chk({tag, "_err"}, 32'(err_o), 32'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      e++;
      #1;
      cmp_all("cyc");
   endtask

   task automatic run_to(input int n);
      while (e < n) tick();
   endtask

   task automatic async_rst();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      cmp_all("arst");
      tick();
      rst = 1'b0;
   endtask

   // Caller sets e = -1 so the next edge is edge 0 with req high.
   task automatic pwr_up_check(input string tag);
      sack = 1'b0;
      req  = 1'b1;
      run_to(0);
      chk({tag, "_e0"}, 32'(sw_en), 32'h0);
      run_to(1);
      chk({tag, "_e1"}, 32'(sw_en), 32'h1);
      run_to(9);
      chk({tag, "_e9"}, 32'(sw_en), 32'h3);
      run_to(17);
      chk({tag, "_e17"}, 32'(sw_en), 32'h7);
      run_to(25);
      chk({tag, "_e25"}, 32'(sw_en), 32'hf);
      run_to(29);
      sack = 1'b1;
      run_to(48);
      chk({tag, "_ack48"}, 32'(ack_o), 32'h0);
      run_to(49);
      chk({tag, "_ack49"}, 32'(ack_o), 32'h1);
   endtask

   initial begin
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_sw_en", 32'(sw_en), 32'h0);
      chk("rst_ack", 32'(ack_o), 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();

      e = -1;
      pwr_up_check("pu");

      sack = 1'b0;
      repeat (5) tick();
      chk("on_sack_drop", 32'(ack_o), 32'h1);

      e = -1;
      req = 1'b0;
      run_to(0);
      chk("pd_t", 32'(ack_o), 32'h1);
      run_to(1);
      chk("pd_t1_ack", 32'(ack_o), 32'h0);
      chk("pd_t1_sw", 32'(sw_en), 32'h7);
      run_to(9);
      chk("pd_t9", 32'(sw_en), 32'h3);
      run_to(17);
      chk("pd_t17", 32'(sw_en), 32'h1);
      run_to(25);
      chk("pd_t25", 32'(sw_en), 32'h0);
      repeat (4) tick();

      e = -1;
      sack = 1'b0;
      req = 1'b1;
      run_to(11);
      req = 1'b0;
      run_to(12);
      chk("ab_e12", 32'(sw_en), 32'h3);
      run_to(19);
      chk("ab_e19", 32'(sw_en), 32'h3);
      run_to(20);
      chk("ab_e20", 32'(sw_en), 32'h1);
      run_to(28);
      chk("ab_e28", 32'(sw_en), 32'h0);
      repeat (4) tick();

      e = -1;
      req = 1'b1;
      run_to(96);
      chk("to_e96", 32'(err_o), 32'h0);
      run_to(97);
      chk("to_e97", 32'(err_o), 32'h1);
      run_to(129);
      chk("to_e129", 32'(sw_en), 32'h0);
      run_to(160);
      chk("to_ign", 32'(sw_en), 32'h0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("to_clr", 32'(err_o), 32'h0);
      e = -1;
      pwr_up_check("pu_clr");

      e = -1;
      req = 1'b0;
      run_to(9);
      chk("rv_e9", 32'(sw_en), 32'h3);
      run_to(11);
      req = 1'b1;
      run_to(19);
      chk("rv_e19", 32'(sw_en), 32'h3);
      run_to(20);
      chk("rv_e20", 32'(sw_en), 32'h7);
      run_to(28);
      chk("rv_e28", 32'(sw_en), 32'hf);
      run_to(52);
      chk("rv_ack", 32'(ack_o), 32'h1);

      req = 1'b0;
      repeat (40) tick();
      e = -1;
      sack = 1'b0;
      req = 1'b1;
      run_to(96);
      clr = 1'b1;
      run_to(97);
      clr = 1'b0;
      chk("set_wins", 32'(err_o), 32'h1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_after", 32'(err_o), 32'h0);
      req = 1'b0;
      repeat (40) tick();

      e = -1;
      req = 1'b1;
      run_to(40);
      async_rst();
      chk("rs_sw", 32'(sw_en), 32'h0);
      e = -1;
      pwr_up_check("pu_rst");

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 29) == 0) req = ~req;
         if ($urandom_range(0, 39) == 0) sack = ~sack;
         clr = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 1499) == 0) async_rst();
         tick();
      end
      clr = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
